// File: rtl/data_memory_map.sv
// Data-side memory map: RAM, screen shadow with a write queue toward the
// display writer, and a keyboard register. Reads return one cycle later.
module data_memory_map #(
    parameter int RAM_WORDS      = 16384,
    parameter int SCR_FIFO_DEPTH = 4
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic [15:0] i_Address,
    input  logic [15:0] i_Mem_Data,
    input  logic        i_Write,
    output logic [15:0] o_Read_Data,
    output logic        o_Busy,
    input  logic        i_Key_Valid,
    input  logic [15:0] i_Key_Code,
    output logic        o_Scr_Valid,
    input  logic        i_Scr_Ready,
    output logic [12:0] o_Scr_Addr,
    output logic [15:0] o_Scr_Data,
    output logic        o_Overflow
);
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW     = (SCR_FIFO_DEPTH > 1) ? $clog2(SCR_FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(SCR_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } scr_entry_t;

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] shadow [8192];
    scr_entry_t  fifo   [SCR_FIFO_DEPTH];

    logic [15:0]       key_reg;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;

    logic              ram_sel, scr_sel, kbd_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [12:0]       scr_idx;
    logic              push, pop, full, push_ok;

    // Address decode; RAM window is further limited to the words actually built.
    always_comb begin
        ram_sel = (i_Address[15:14] == 2'b00) && (int'(i_Address) < RAM_WORDS);
        scr_sel = (i_Address[15:13] == 3'b010);
        kbd_sel = (i_Address == 16'h6000);
        ram_idx = i_Address[RAM_AW-1:0];
        scr_idx = i_Address[12:0];
    end

    // Queue control: a full queue still accepts a push when the head leaves
    // on the same edge; an empty queue never bypasses since valid is low.
    always_comb begin
        full     = (count == CW'(SCR_FIFO_DEPTH));
        push     = i_Write && scr_sel;
        pop      = o_Scr_Valid && i_Scr_Ready;
        push_ok  = push && (!full || pop);
    end

    assign o_Scr_Valid = (count != '0);
    assign o_Busy      = full;
    assign o_Overflow  = overflow;
    assign o_Scr_Addr  = fifo[rd_ptr].addr;
    assign o_Scr_Data  = fifo[rd_ptr].data;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(SCR_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage arrays: no reset so RAM and screen contents survive it.
    always_ff @(posedge i_CLK) begin
        if (i_Write && ram_sel) ram[ram_idx] <= i_Mem_Data;
        if (push) shadow[scr_idx] <= i_Mem_Data;
        if (push_ok) fifo[wr_ptr] <= '{addr: scr_idx, data: i_Mem_Data};
    end

    // Registered read mux; nonblocking storage writes make this read-first.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET)      o_Read_Data <= '0;
        else if (ram_sel) o_Read_Data <= ram[ram_idx];
        else if (scr_sel) o_Read_Data <= shadow[scr_idx];
        else if (kbd_sel) o_Read_Data <= key_reg;
        else              o_Read_Data <= '0;
    end

    // Keyboard register follows the key strobe.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET)          key_reg <= '0;
        else if (i_Key_Valid) key_reg <= i_Key_Code;
    end

    // Queue pointers, occupancy and the sticky drop flag.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop)     rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end
endmodule
